// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory access unit.
//   - access size encodings carried on req_size
//   - exception codes reported on resp_exccode
//   - FSM state encoding of the access unit
//   - default address-map constants
//   - misaligned(): alignment rule for a size/offset pair
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] DM_LIMIT_DEF = 32'h0000_3000;
  localparam logic [31:0] DEV_BASE_DEF = 32'h0000_7f00;
  localparam logic [31:0] DEV_END_DEF  = 32'h0000_7f23;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Reserved size is reported as misaligned so it raises an address exception.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// mem_lane_ext: combinational byte-lane logic.
//   off   in  2  : byte offset within the word (addr[1:0])
//   size  in  2  : access size
//   sign  in  1  : 1 sign-extends loads, 0 zero-extends
//   wdata in  32 : right-aligned store data
//   rdata in  32 : whole word read from memory/device
//   be    out 4  : byte enables
//   wrep  out 32 : store data replicated across lanes
//   rext  out 32 : extracted and extended load data
module mem_lane_ext
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Enables and lane replication for stores.
  always_comb begin
    be   = 4'b0000;
    wrep = wdata;
    case (size)
      SZ_BYTE: begin
        be   = 4'b0001 << off;
        wrep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be   = 4'b1111;
        wrep = wdata;
      end
      default: begin
        be   = 4'b0000;
        wrep = wdata;
      end
    endcase
  end

  // Load lane selection and extension.
  always_comb begin
    case (off)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: rext = {{24{sign & byte_v[7]}}, byte_v};
      SZ_HALF: rext = {{16{sign & half_v[15]}}, half_v};
      SZ_WORD: rext = rdata;
      default: rext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the byte-enabled data-memory port.
// Accepts one load/store at a time over req_valid/req_ready, checks
// alignment and address range, drives one memory cycle and returns one
// response pulse with extended load data or an address exception.
//   clk, reset                 : clock, async active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we/size/sign/addr/wdata/pc : request fields
//   resp_valid/rdata/exc/exccode   : one-cycle response
//   mem_addr/wdata/be/we/pc, dev_sel : memory/device drive
//   mem_rdata                  : combinational read data
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEF,
  parameter logic [31:0] DEV_BASE = DEV_BASE_DEF,
  parameter logic [31:0] DEV_END  = DEV_END_DEF,
  parameter logic [3:0]  DEV_WAIT = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exccode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic [31:0] mem_pc,
  output logic        dev_sel,
  input  logic [31:0] mem_rdata
);

  state_t      state_r, state_nxt;
  logic        we_r, we_nxt;
  logic [1:0]  size_r, size_nxt;
  logic        sign_r, sign_nxt;
  logic [3:0]  cnt_r, cnt_nxt;

  logic        resp_valid_nxt, resp_exc_nxt, mem_we_nxt, dev_sel_nxt;
  logic [31:0] resp_rdata_nxt, mem_addr_nxt, mem_wdata_nxt, mem_pc_nxt;
  logic [4:0]  resp_exccode_nxt;
  logic [3:0]  mem_be_nxt;

  logic        hit_dm, hit_dev, req_bad;
  logic [1:0]  lane_off, lane_size;
  logic [3:0]  lane_be;
  logic [31:0] lane_wrep, lane_rext, load_data;

  // mem_addr doubles as the latched request address once accepted.
  assign lane_off  = (state_r == ST_IDLE) ? req_addr[1:0] : mem_addr[1:0];
  assign lane_size = (state_r == ST_IDLE) ? req_size : size_r;

  mem_lane_ext u_lane (
    .off   (lane_off),
    .size  (lane_size),
    .sign  (sign_r),
    .wdata (req_wdata),
    .rdata (mem_rdata),
    .be    (lane_be),
    .wrep  (lane_wrep),
    .rext  (lane_rext)
  );

  assign hit_dm    = (req_addr < DM_LIMIT);
  assign hit_dev   = (req_addr >= DEV_BASE) && (req_addr <= DEV_END);
  // Device registers are word-only.
  assign req_bad   = misaligned(req_size, req_addr[1:0]) || !(hit_dm || hit_dev) ||
                     (hit_dev && (req_size != SZ_WORD));
  assign load_data = we_r ? 32'h0000_0000 : lane_rext;
  assign req_ready = (state_r == ST_IDLE);

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_nxt        = state_r;
    we_nxt           = we_r;
    size_nxt         = size_r;
    sign_nxt         = sign_r;
    cnt_nxt          = cnt_r;
    resp_valid_nxt   = 1'b0;
    resp_rdata_nxt   = resp_rdata;
    resp_exc_nxt     = resp_exc;
    resp_exccode_nxt = resp_exccode;
    mem_addr_nxt     = mem_addr;
    mem_wdata_nxt    = mem_wdata;
    mem_be_nxt       = 4'b0000;
    mem_we_nxt       = 1'b0;
    mem_pc_nxt       = mem_pc;
    dev_sel_nxt      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          we_nxt   = req_we;
          size_nxt = req_size;
          sign_nxt = req_sign;
          if (req_bad) begin
            state_nxt        = ST_RESP;
            resp_valid_nxt   = 1'b1;
            resp_exc_nxt     = 1'b1;
            resp_exccode_nxt = req_we ? EXC_ADES : EXC_ADEL;
            resp_rdata_nxt   = 32'h0000_0000;
          end else begin
            state_nxt     = ST_ACCESS;
            mem_addr_nxt  = req_addr;
            mem_wdata_nxt = lane_wrep;
            mem_be_nxt    = lane_be;
            mem_we_nxt    = req_we;
            mem_pc_nxt    = req_pc;
            dev_sel_nxt   = hit_dev;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (dev_sel && (DEV_WAIT != 4'd0)) begin
          state_nxt   = ST_WAIT;
          cnt_nxt     = DEV_WAIT;
          mem_be_nxt  = mem_be;
          dev_sel_nxt = dev_sel;
        end else begin
          state_nxt        = ST_RESP;
          resp_valid_nxt   = 1'b1;
          resp_exc_nxt     = 1'b0;
          resp_exccode_nxt = EXC_NONE;
          resp_rdata_nxt   = load_data;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_nxt        = ST_RESP;
          resp_valid_nxt   = 1'b1;
          resp_exc_nxt     = 1'b0;
          resp_exccode_nxt = EXC_NONE;
          resp_rdata_nxt   = load_data;
        end else begin
          cnt_nxt     = cnt_r - 4'd1;
          mem_be_nxt  = mem_be;
          dev_sel_nxt = dev_sel;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      size_r       <= SZ_BYTE;
      sign_r       <= 1'b0;
      cnt_r        <= 4'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0000_0000;
      resp_exc     <= 1'b0;
      resp_exccode <= 5'd0;
      mem_addr     <= 32'h0000_0000;
      mem_wdata    <= 32'h0000_0000;
      mem_be       <= 4'b0000;
      mem_we       <= 1'b0;
      mem_pc       <= 32'h0000_0000;
      dev_sel      <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      we_r         <= we_nxt;
      size_r       <= size_nxt;
      sign_r       <= sign_nxt;
      cnt_r        <= cnt_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_rdata   <= resp_rdata_nxt;
      resp_exc     <= resp_exc_nxt;
      resp_exccode <= resp_exccode_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      mem_be       <= mem_be_nxt;
      mem_we       <= mem_we_nxt;
      mem_pc       <= mem_pc_nxt;
      dev_sel      <= dev_sel_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store requests against a
// behavioural model of the address map, lane rules and latencies.
module tb_mem_access_unit;

  localparam logic [3:0] WAITS = 4'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_exc, mem_we, dev_sel;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic [4:0]  resp_exccode;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.DEV_WAIT(WAITS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_exccode(resp_exccode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_we(mem_we), .mem_pc(mem_pc), .dev_sel(dev_sel),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One request through the whole handshake, compared against the model.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc,
                         input logic [31:0] rdata);
    int          off, lat, pulses, exp_lat;
    logic        in_dm, in_dev, misal, exp_exc;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, v;
    logic [4:0]  exp_code;

    off    = int'(addr % 4);
    in_dm  = addr < 32'h0000_3000;
    in_dev = (addr >= 32'h0000_7f00) && (addr <= 32'h0000_7f23);
    misal  = (size == 2'd3) ? 1'b1 : ((off % (1 << size)) != 0);
    exp_exc  = misal || !(in_dm || in_dev) || (in_dev && size != 2'd2);
    exp_code = exp_exc ? (we ? 5'd5 : 5'd4) : 5'd0;
    exp_lat  = exp_exc ? 1 : (in_dev ? 2 + int'(WAITS) : 2);
    case (size)
      2'd0: begin
        exp_be = 4'(1 << off);
        exp_wd = {24'd0, wdata[7:0]} * 32'h0101_0101;
      end
      2'd1: begin
        exp_be = 4'(3 << off);
        exp_wd = {16'd0, wdata[15:0]} * 32'h0001_0001;
      end
      default: begin
        exp_be = 4'hf;
        exp_wd = wdata;
      end
    endcase
    v = rdata >> (8 * off);
    if (size == 2'd0) begin
      v = v & 32'hff;
      if (sign && v >= 32'h80) v = v + 32'hffff_ff00;
    end else if (size == 2'd1) begin
      v = v & 32'hffff;
      if (sign && v >= 32'h8000) v = v + 32'hffff_0000;
    end
    exp_rd = (we || exp_exc) ? 32'd0 : v;

    @(negedge clk);
    check({tag, ":ready"}, {31'd0, req_ready}, 32'd1);
    req_we = we; req_size = size; req_sign = sign; req_addr = addr;
    req_wdata = wdata; req_pc = pc; mem_rdata = rdata; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
    req_we    = ~we; req_sign = ~sign; req_pc = $urandom;
    lat = 0; pulses = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (mem_we) pulses++;
      if (n == 1 && !exp_exc) begin
        check({tag, ":be"},    {28'd0, mem_be}, {28'd0, exp_be});
        check({tag, ":addr"},  mem_addr, addr);
        check({tag, ":pc"},    mem_pc, pc);
        check({tag, ":dev"},   {31'd0, dev_sel}, {31'd0, in_dev});
        check({tag, ":busy"},  {31'd0, req_ready}, 32'd0);
        if (we) check({tag, ":wdata"}, mem_wdata, exp_wd);
        else    check({tag, ":we0"}, {31'd0, mem_we}, 32'd0);
      end
      if (n > 1 && !exp_exc && in_dev && !resp_valid) begin
        check({tag, ":wait_dev"}, {31'd0, dev_sel}, 32'd1);
        check({tag, ":wait_be"},  {28'd0, mem_be}, {28'd0, exp_be});
      end
      if (resp_valid) lat = n;
    end
    check({tag, ":lat"},    lat, exp_lat);
    check({tag, ":pulses"}, pulses, (we && !exp_exc) ? 1 : 0);
    check({tag, ":rdata"},  resp_rdata, exp_rd);
    check({tag, ":exc"},    {31'd0, resp_exc}, {31'd0, exp_exc});
    check({tag, ":code"},   {27'd0, resp_exccode}, {27'd0, exp_code});
    @(negedge clk);
    check({tag, ":pulse1"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ":be_off"}, {27'd0, mem_be, mem_we}, 32'd0);
    check({tag, ":dev_off"}, {31'd0, dev_sel}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_pc = 32'd0; mem_rdata = 32'd0;
    #3;
    check("rst_outs", {resp_valid, resp_exc, mem_we, dev_sel}, 32'd0);
    check("rst_data", resp_rdata | mem_addr | mem_wdata | mem_pc, 32'd0);
    check("rst_be_code", {23'd0, mem_be, resp_exccode}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check("first_ready", {31'd0, req_ready}, 32'd1);

    run_req("sw_dm",    1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0040_0000, 32'h0);
    run_req("sb_13",    1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00ab, 32'h0040_0004, 32'h0);
    run_req("lb_s",     1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 32'h0040_0008, 32'hab00_0000);
    run_req("lb_u",     1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 32'h0040_000c, 32'hab00_0000);
    run_req("lh_s",     1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 32'h0040_0010, 32'h8001_0000);
    run_req("lw_mis",   1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 32'h0040_0014, 32'h0);
    run_req("sh_lim",   1'b1, 2'd1, 1'b0, 32'h0000_3000, 32'h1111, 32'h0040_0018, 32'h0);
    run_req("sw_dev",   1'b1, 2'd2, 1'b0, 32'h0000_7f04, 32'hcafe_f00d, 32'h0040_001c, 32'h0);
    run_req("sb_dev",   1'b1, 2'd0, 1'b0, 32'h0000_7f04, 32'h55, 32'h0040_0020, 32'h0);
    run_req("lw_top",   1'b0, 2'd2, 1'b0, 32'h0000_2ffc, 32'h0, 32'h0040_0024, 32'h89ab_cdef);
    run_req("lw_devend", 1'b0, 2'd2, 1'b0, 32'h0000_7f20, 32'h0, 32'h0040_0028, 32'h0bad_beef);
    run_req("lw_devout", 1'b0, 2'd2, 1'b0, 32'h0000_7f24, 32'h0, 32'h0040_002c, 32'h0);
    run_req("lw_below", 1'b0, 2'd2, 1'b0, 32'h0000_7efc, 32'h0, 32'h0040_0030, 32'h0);
    run_req("rsvd",     1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 32'h0040_0034, 32'h0);
    run_req("lh_hi_u",  1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 32'h0040_0038, 32'hf00f_1234);

    // Reset asserted in the middle of a store's memory cycle.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_sign = 1'b0; req_addr = 32'h0000_0020;
    req_wdata = 32'hdead_beef; req_pc = 32'h0040_0100; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1;
    check("rst_mid_we_before", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_we_drop", {31'd0, mem_we}, 32'd0);
    check("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("rst_mid_noresp", {31'd0, resp_valid}, 32'd0);
      check("rst_mid_idle", {31'd0, req_ready}, 32'd1);
    end
    run_req("after_rst", 1'b0, 2'd1, 1'b1, 32'h0000_0040, 32'h0, 32'h0040_0104, 32'h0000_fffe);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 32'h2fff);
        1:       a = 32'h0000_3000 - $urandom_range(1, 8) + $urandom_range(0, 4);
        2:       a = 32'h0000_7efc + $urandom_range(0, 44);
        default: a = $urandom;
      endcase
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      run_req("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              $urandom, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
